// File: rtl/control_unit.sv
// RV32I ID-stage control decoder with a one-deep registered copy of the memory-side controls.
// Define CONTROL_UNIT_ILLEGAL_DETECT_EN to drive illegal_instr; otherwise that port is tied to 0.
module control_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic [31:0]     Instruction,
    input  logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_Plus4,
    output logic            ID_load_Instr,
    output logic            ID_RF_enable,
    output logic            RAM_Enable,
    output logic            RAM_RW,
    output logic            RAM_SE,
    output logic [1:0]      RAM_Size,
    output logic            jump_instr,
    output logic            JALR_Instr,
    output logic            JAL_Instr,
    output logic            AUIPC_Instr,
    output logic [2:0]      ID_shift_imm,
    output logic [3:0]      ID_ALU_op,
    output logic [9:0]      Comb_OpFunct,
    output logic            Mem_load_Instr,
    output logic            Mem_RF_enable,
    output logic            Mem_RAM_Enable,
    output logic            Mem_RAM_RW,
    output logic            Mem_RAM_SE,
    output logic [1:0]      Mem_RAM_Size,
    output logic            illegal_instr
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLL    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_SLT    = 4'b1000,
        ALU_SLTU   = 4'b1001,
        ALU_PASS_B = 4'b1010,
        ALU_PASS_A = 4'b1011
    } alu_op_e;

    typedef enum logic [2:0] {
        OPND_RS2   = 3'b000,
        OPND_IMM_I = 3'b001,
        OPND_IMM_S = 3'b010,
        OPND_IMM_B = 3'b011,
        OPND_IMM_U = 3'b100,
        OPND_IMM_J = 3'b101,
        OPND_SHAMT = 3'b110
    } opnd_sel_e;

    typedef struct packed {
        logic       load;
        logic       rf_en;
        logic       ram_en;
        logic       ram_rw;
        logic       ram_se;
        logic [1:0] ram_size;
    } mem_ctrl_t;

    typedef struct packed {
        mem_ctrl_t mem;
        logic      jump;
        logic      jalr;
        logic      jal;
        logic      auipc;
        opnd_sel_e opnd;
        alu_op_e   alu;
    } decode_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    decode_t    dec;
    logic       legal;
    mem_ctrl_t  mem_d;
    mem_ctrl_t  mem_q;
    logic       unused_instr_bits;

    assign opcode = Instruction[6:0];
    assign funct3 = Instruction[14:12];
    assign funct7 = Instruction[31:25];

    // Register and immediate fields are consumed downstream, not by the decoder.
    assign unused_instr_bits = ^{Instruction[24:15], Instruction[11:7]};

    assign PC_Plus4     = PC + XLEN'(4);
    assign Comb_OpFunct = {opcode, funct3};

    always_comb begin
        // NOTE: defaults first, so any path the case leaves unassigned cannot infer a latch.
        dec   = '0;
        legal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                dec.mem.rf_en = 1'b1;
                dec.opnd      = OPND_IMM_I;
                legal         = 1'b1;
                case (funct3)
                    3'b000: dec.alu = ALU_ADD;
                    3'b010: dec.alu = ALU_SLT;
                    3'b011: dec.alu = ALU_SLTU;
                    3'b100: dec.alu = ALU_XOR;
                    3'b110: dec.alu = ALU_OR;
                    3'b111: dec.alu = ALU_AND;
                    3'b001: begin
                        dec.alu  = ALU_SLL;
                        dec.opnd = OPND_SHAMT;
                        legal    = (funct7 == 7'h00);
                    end
                    default: begin
                        dec.alu  = funct7[5] ? ALU_SRA : ALU_SRL;
                        dec.opnd = OPND_SHAMT;
                        legal    = (funct7 == 7'h00) || (funct7 == 7'h20);
                    end
                endcase
            end
            OPC_OP: begin
                dec.mem.rf_en = 1'b1;
                dec.opnd      = OPND_RS2;
                // funct7[5] is only meaningful for ADD/SUB and SRL/SRA.
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                case (funct3)
                    3'b000:  dec.alu = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  dec.alu = ALU_SLL;
                    3'b010:  dec.alu = ALU_SLT;
                    3'b011:  dec.alu = ALU_SLTU;
                    3'b100:  dec.alu = ALU_XOR;
                    3'b101:  dec.alu = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec.alu = ALU_OR;
                    default: dec.alu = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                dec.mem.load     = 1'b1;
                dec.mem.rf_en    = 1'b1;
                dec.mem.ram_en   = 1'b1;
                dec.mem.ram_rw   = 1'b0;
                dec.mem.ram_size = funct3[1:0];
                dec.mem.ram_se   = ~funct3[2];
                dec.alu          = ALU_ADD;
                dec.opnd         = OPND_IMM_I;
                legal            = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                                   (funct3 == 3'b100) || (funct3 == 3'b101);
            end
            OPC_STORE: begin
                dec.mem.ram_en   = 1'b1;
                dec.mem.ram_rw   = 1'b1;
                dec.mem.ram_size = funct3[1:0];
                dec.alu          = ALU_ADD;
                dec.opnd         = OPND_IMM_S;
                legal            = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
            end
            OPC_BRANCH: begin
                dec.jump = 1'b1;
                dec.alu  = ALU_SUB;
                dec.opnd = OPND_IMM_B;
                legal    = (funct3[2:1] != 2'b01);
            end
            OPC_JAL: begin
                dec.jump      = 1'b1;
                dec.jal       = 1'b1;
                dec.mem.rf_en = 1'b1;
                dec.alu       = ALU_PASS_A;
                dec.opnd      = OPND_IMM_J;
                legal         = 1'b1;
            end
            OPC_JALR: begin
                dec.jump      = 1'b1;
                dec.jalr      = 1'b1;
                dec.mem.rf_en = 1'b1;
                dec.alu       = ALU_PASS_A;
                dec.opnd      = OPND_IMM_I;
                legal         = (funct3 == 3'b000);
            end
            OPC_LUI: begin
                dec.mem.rf_en = 1'b1;
                dec.alu       = ALU_PASS_B;
                dec.opnd      = OPND_IMM_U;
                legal         = 1'b1;
            end
            OPC_AUIPC: begin
                dec.mem.rf_en = 1'b1;
                dec.auipc     = 1'b1;
                dec.alu       = ALU_ADD;
                dec.opnd      = OPND_IMM_U;
                legal         = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Unsupported encodings must look like a bubble to every consumer.
        if (!legal) begin
            dec = '0;
        end
    end

    assign ID_load_Instr = dec.mem.load;
    assign ID_RF_enable  = dec.mem.rf_en;
    assign RAM_Enable    = dec.mem.ram_en;
    assign RAM_RW        = dec.mem.ram_rw;
    assign RAM_SE        = dec.mem.ram_se;
    assign RAM_Size      = dec.mem.ram_size;
    assign jump_instr    = dec.jump;
    assign JALR_Instr    = dec.jalr;
    assign JAL_Instr     = dec.jal;
    assign AUIPC_Instr   = dec.auipc;
    assign ID_shift_imm  = dec.opnd;
    assign ID_ALU_op     = dec.alu;

`ifdef CONTROL_UNIT_ILLEGAL_DETECT_EN
    assign illegal_instr = ~legal;
`else
    assign illegal_instr = 1'b0;
`endif

    always_comb begin
        mem_d = dec.mem;
    end

    always_ff @(posedge clk or negedge Reset) begin
        // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
        if (!Reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign Mem_load_Instr = mem_q.load;
    assign Mem_RF_enable  = mem_q.rf_en;
    assign Mem_RAM_Enable = mem_q.ram_en;
    assign Mem_RAM_RW     = mem_q.ram_rw;
    assign Mem_RAM_SE     = mem_q.ram_se;
    assign Mem_RAM_Size   = mem_q.ram_size;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a driver queues hand-computed expectations per vector,
// a monitor compares decode outputs and the registered Mem_* copy one edge later.
module tb_control_unit;

`ifdef CONTROL_UNIT_ILLEGAL_DETECT_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk;
    logic        Reset;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] PC_Plus4;
    logic        ID_load_Instr, ID_RF_enable, RAM_Enable, RAM_RW, RAM_SE;
    logic [1:0]  RAM_Size;
    logic        jump_instr, JALR_Instr, JAL_Instr, AUIPC_Instr;
    logic [2:0]  ID_shift_imm;
    logic [3:0]  ID_ALU_op;
    logic [9:0]  Comb_OpFunct;
    logic        Mem_load_Instr, Mem_RF_enable, Mem_RAM_Enable, Mem_RAM_RW, Mem_RAM_SE;
    logic [1:0]  Mem_RAM_Size;
    logic        illegal_instr;

    control_unit #(.XLEN(32)) dut (
        .clk(clk), .Reset(Reset), .Instruction(Instruction), .PC(PC), .PC_Plus4(PC_Plus4),
        .ID_load_Instr(ID_load_Instr), .ID_RF_enable(ID_RF_enable),
        .RAM_Enable(RAM_Enable), .RAM_RW(RAM_RW), .RAM_SE(RAM_SE), .RAM_Size(RAM_Size),
        .jump_instr(jump_instr), .JALR_Instr(JALR_Instr), .JAL_Instr(JAL_Instr),
        .AUIPC_Instr(AUIPC_Instr), .ID_shift_imm(ID_shift_imm), .ID_ALU_op(ID_ALU_op),
        .Comb_OpFunct(Comb_OpFunct), .Mem_load_Instr(Mem_load_Instr),
        .Mem_RF_enable(Mem_RF_enable), .Mem_RAM_Enable(Mem_RAM_Enable),
        .Mem_RAM_RW(Mem_RAM_RW), .Mem_RAM_SE(Mem_RAM_SE), .Mem_RAM_Size(Mem_RAM_Size),
        .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag order: {load, rf_en, ram_en, ram_rw, ram_se, ram_size[1:0], jump, jalr, jal, auipc}
    typedef struct {
        string       name;
        logic [31:0] pc4;
        logic [10:0] flags;
        logic [2:0]  sh;
        logic [3:0]  alu;
        logic [9:0]  opf;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [10:0] dec_act;
    logic [6:0]  mem_act;
    assign dec_act = {ID_load_Instr, ID_RF_enable, RAM_Enable, RAM_RW, RAM_SE, RAM_Size,
                      jump_instr, JALR_Instr, JAL_Instr, AUIPC_Instr};
    assign mem_act = {Mem_load_Instr, Mem_RF_enable, Mem_RAM_Enable, Mem_RAM_RW,
                      Mem_RAM_SE, Mem_RAM_Size};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input string name, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic [10:0] flags, input logic [2:0] sh,
                         input logic [3:0] alu, input logic [9:0] opf, input logic ill);
        exp_t e;
        @(negedge clk);
        Instruction = instr;
        PC          = pc;
        e.name = name; e.pc4 = pc4; e.flags = flags; e.sh = sh;
        e.alu = alu; e.opf = opf; e.ill = ill & ILL_EN;
        exp_q.push_back(e);
    endtask

    // Monitor: reset events check the cleared stage, rising edges retire one expectation.
    initial begin
        exp_t e;
        #2;
        check("reset_mem", 32'(mem_act), 32'h0);
        forever begin
            @(posedge clk or negedge Reset);
            #1;
            if (!Reset) begin
                check("async_reset_mem", 32'(mem_act), 32'h0);
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.name, "_pc4"},   PC_Plus4,          e.pc4);
                check({e.name, "_flags"}, 32'(dec_act),      32'(e.flags));
                check({e.name, "_sh"},    32'(ID_shift_imm), 32'(e.sh));
                check({e.name, "_alu"},   32'(ID_ALU_op),    32'(e.alu));
                check({e.name, "_opf"},   32'(Comb_OpFunct), 32'(e.opf));
                check({e.name, "_ill"},   32'(illegal_instr), 32'(e.ill));
                check({e.name, "_mem"},   32'(mem_act),      32'(e.flags[10:4]));
            end
        end
    end

    // Driver
    initial begin
        Reset       = 1'b0;
        Instruction = 32'h0;
        PC          = 32'h0;
        #3 Reset = 1'b1;

        issue("addi",  32'h00500093, 32'h000001FC, 32'h00000200, 11'b0_1_0_0_0_00_0_0_0_0, 3'b001, 4'b0000, 10'b0010011_000, 1'b0);
        issue("lw",    32'h0000A103, 32'hFFFFFFFC, 32'h00000000, 11'b1_1_1_0_1_10_0_0_0_0, 3'b001, 4'b0000, 10'b0000011_010, 1'b0);
        issue("sb",    32'h00208023, 32'h00000100, 32'h00000104, 11'b0_0_1_1_0_00_0_0_0_0, 3'b010, 4'b0000, 10'b0100011_000, 1'b0);
        // Mid-cycle reset while the LW copy is held; SB must still be captured afterwards.
        #1 Reset = 1'b0;
        #3 Reset = 1'b1;
        issue("jal",   32'h008000EF, 32'h00000010, 32'h00000014, 11'b0_1_0_0_0_00_1_0_1_0, 3'b101, 4'b1011, 10'b1101111_000, 1'b0);
        issue("zero",  32'h00000000, 32'h00000020, 32'h00000024, 11'b0_0_0_0_0_00_0_0_0_0, 3'b000, 4'b0000, 10'b0000000_000, 1'b1);
        issue("sub",   32'h40208133, 32'h7FFFFFFC, 32'h80000000, 11'b0_1_0_0_0_00_0_0_0_0, 3'b000, 4'b0001, 10'b0110011_000, 1'b0);
        issue("srai",  32'h4030D093, 32'h00000004, 32'h00000008, 11'b0_1_0_0_0_00_0_0_0_0, 3'b110, 4'b0111, 10'b0010011_101, 1'b0);
        issue("beq",   32'h00208463, 32'h00000008, 32'h0000000C, 11'b0_0_0_0_0_00_1_0_0_0, 3'b011, 4'b0001, 10'b1100011_000, 1'b0);
        issue("jalr",  32'h000080E7, 32'h0000000C, 32'h00000010, 11'b0_1_0_0_0_00_1_1_0_0, 3'b001, 4'b1011, 10'b1100111_000, 1'b0);
        issue("lui",   32'h123450B7, 32'h00000010, 32'h00000014, 11'b0_1_0_0_0_00_0_0_0_0, 3'b100, 4'b1010, 10'b0110111_101, 1'b0);
        issue("auipc", 32'h00001097, 32'h00000014, 32'h00000018, 11'b0_1_0_0_0_00_0_0_0_1, 3'b100, 4'b0000, 10'b0010111_001, 1'b0);
        issue("lbu",   32'h0000C103, 32'h00000018, 32'h0000001C, 11'b1_1_1_0_0_00_0_0_0_0, 3'b001, 4'b0000, 10'b0000011_100, 1'b0);
        issue("sltu",  32'h0020B133, 32'h0000001C, 32'h00000020, 11'b0_1_0_0_0_00_0_0_0_0, 3'b000, 4'b1001, 10'b0110011_011, 1'b0);
        issue("mul",   32'h02208133, 32'h00000020, 32'h00000024, 11'b0_0_0_0_0_00_0_0_0_0, 3'b000, 4'b0000, 10'b0110011_000, 1'b1);
        issue("ecall", 32'h00000073, 32'h00000024, 32'h00000028, 11'b0_0_0_0_0_00_0_0_0_0, 3'b000, 4'b0000, 10'b1110011_000, 1'b1);
        issue("sh",    32'h00209023, 32'h00000028, 32'h0000002C, 11'b0_0_1_1_0_01_0_0_0_0, 3'b010, 4'b0000, 10'b0100011_001, 1'b0);
        issue("andi",  32'h0FF0F093, 32'h0000002C, 32'h00000030, 11'b0_1_0_0_0_00_0_0_0_0, 3'b001, 4'b0010, 10'b0010011_111, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
